// File: rtl/anton_neopixel_serializer_if.sv
// Pixel-buffer handshake and frame control bundle for the NeoPixel serializer.
// The master side is the controller/pixel buffer; the slave side is the serializer.
interface anton_neopixel_serializer_if #(
  parameter int BUFFER_BITS = 3
);
  logic                   start;
  logic                   loop_en;
  logic [BUFFER_BITS-1:0] last_pixel;
  logic                   pixel_req;
  logic [BUFFER_BITS-1:0] pixel_index;
  logic                   pixel_valid;
  logic [31:0]            pixel_data;
  logic                   busy;
  logic                   done;
  logic                   underrun;
  logic                   neo_data;

  modport master (
    output start, loop_en, last_pixel, pixel_valid, pixel_data,
    input  pixel_req, pixel_index, busy, done, underrun, neo_data
  );

  modport slave (
    input  start, loop_en, last_pixel, pixel_valid, pixel_data,
    output pixel_req, pixel_index, busy, done, underrun, neo_data
  );
endinterface

// File: rtl/anton_neopixel_serializer.sv
// WS281x serializer: fetches pixels over req/valid, shifts them out MSB-first with
// cycle-counted high times, prefetches the next pixel and ends each frame with a latch gap.
module anton_neopixel_serializer #(
  parameter int CLK_PER_BIT    = 8,
  parameter int T0H            = 2,
  parameter int T1H            = 5,
  parameter int RESET_CYCLES   = 350,
  parameter int BITS_PER_PIXEL = 24,
  parameter int BUFFER_END     = 7
) (
  input  logic                         clk,
  input  logic                         rst,
  anton_neopixel_serializer_if.slave   bus
);

  localparam int BUFFER_BITS = (BUFFER_END > 0) ? $clog2(BUFFER_END + 1) : 1;
  localparam int SLOT_W      = $clog2(CLK_PER_BIT);
  localparam int BIT_W       = $clog2(BITS_PER_PIXEL);
  localparam int LATCH_W     = $clog2(RESET_CYCLES + 1);

  localparam logic [SLOT_W-1:0]      SLOT_LAST  = SLOT_W'(CLK_PER_BIT - 1);
  localparam logic [SLOT_W-1:0]      T0H_C      = SLOT_W'(T0H);
  localparam logic [SLOT_W-1:0]      T1H_C      = SLOT_W'(T1H);
  localparam logic [BIT_W-1:0]       BIT_TOP    = BIT_W'(BITS_PER_PIXEL - 1);
  localparam logic [LATCH_W-1:0]     LATCH_LAST = LATCH_W'(RESET_CYCLES - 1);
  localparam logic [BUFFER_BITS-1:0] LAST_MAX   = BUFFER_BITS'(BUFFER_END);
  localparam logic [BUFFER_BITS-1:0] INDEX_ONE  = BUFFER_BITS'(1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    TRANSMIT,
    LATCH
  } state_t;

  state_t                    state_reg, state_next;
  logic [BUFFER_BITS-1:0]    index_reg, index_next;
  logic [BUFFER_BITS-1:0]    last_reg, last_next;
  logic [BITS_PER_PIXEL-1:0] shift_reg, shift_next;
  logic [BITS_PER_PIXEL-1:0] shadow_reg, shadow_next;
  logic                      shadow_full_reg, shadow_full_next;
  logic [SLOT_W-1:0]         slot_reg, slot_next;
  logic [BIT_W-1:0]          bit_reg, bit_next;
  logic [LATCH_W-1:0]        latch_reg, latch_next;
  logic                      underrun_reg, underrun_next;
  logic                      done_reg, done_next;
  logic                      neo_reg, neo_next;

  logic                      req;
  logic [BUFFER_BITS-1:0]    req_index;
  logic                      prefetch_en;
  logic [BUFFER_BITS-1:0]    last_clamped;
  logic [BITS_PER_PIXEL-1:0] data_word;
  logic                      unused_data;

  assign last_clamped = (bus.last_pixel > LAST_MAX) ? LAST_MAX : bus.last_pixel;
  assign data_word    = bus.pixel_data[BITS_PER_PIXEL-1:0];
  assign unused_data  = ^bus.pixel_data;
  assign prefetch_en  = (index_reg != last_reg) && !shadow_full_reg;

  always_comb begin
    state_next       = state_reg;
    index_next       = index_reg;
    last_next        = last_reg;
    shift_next       = shift_reg;
    shadow_next      = shadow_reg;
    shadow_full_next = shadow_full_reg;
    slot_next        = slot_reg;
    bit_next         = bit_reg;
    latch_next       = latch_reg;
    underrun_next    = underrun_reg;
    done_next        = 1'b0;
    req              = 1'b0;
    req_index        = index_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          last_next        = last_clamped;
          index_next       = '0;
          underrun_next    = 1'b0;
          shadow_full_next = 1'b0;
          state_next       = FETCH;
        end
      end

      FETCH: begin
        req = 1'b1;
        if (bus.pixel_valid) begin
          shift_next = data_word;
          slot_next  = '0;
          bit_next   = BIT_TOP;
          state_next = TRANSMIT;
        end
      end

      TRANSMIT: begin
        // Fetch the following pixel into the shadow while the current one shifts out.
        if (prefetch_en) begin
          req       = 1'b1;
          req_index = index_reg + INDEX_ONE;
          if (bus.pixel_valid) begin
            shadow_next      = data_word;
            shadow_full_next = 1'b1;
          end
        end

        if (slot_reg == SLOT_LAST) begin
          slot_next = '0;
          if (bit_reg == '0) begin
            if (index_reg == last_reg) begin
              latch_next = '0;
              state_next = LATCH;
            end else if (shadow_full_reg) begin
              shift_next       = shadow_reg;
              shadow_full_next = 1'b0;
              index_next       = index_reg + INDEX_ONE;
              bit_next         = BIT_TOP;
            end else if (bus.pixel_valid) begin
              // Prefetch answered exactly on the boundary: use it directly, no gap.
              shift_next       = data_word;
              shadow_full_next = 1'b0;
              index_next       = index_reg + INDEX_ONE;
              bit_next         = BIT_TOP;
            end else begin
              underrun_next = 1'b1;
              index_next    = index_reg + INDEX_ONE;
              state_next    = FETCH;
            end
          end else begin
            bit_next   = bit_reg - 1'b1;
            shift_next = {shift_reg[BITS_PER_PIXEL-2:0], 1'b0};
          end
        end else begin
          slot_next = slot_reg + 1'b1;
        end
      end

      LATCH: begin
        if (latch_reg == LATCH_LAST) begin
          shadow_full_next = 1'b0;
          if (bus.loop_en) begin
            index_next = '0;
            state_next = FETCH;
          end else begin
            done_next  = 1'b1;
            state_next = IDLE;
          end
        end else begin
          latch_next = latch_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The line is registered from next-state values so the first slot is high in the first TRANSMIT cycle.
  always_comb begin
    neo_next = 1'b0;
    if (state_next == TRANSMIT) begin
      neo_next = slot_next < (shift_next[BITS_PER_PIXEL-1] ? T1H_C : T0H_C);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      index_reg       <= '0;
      last_reg        <= '0;
      shift_reg       <= '0;
      shadow_reg      <= '0;
      shadow_full_reg <= 1'b0;
      slot_reg        <= '0;
      bit_reg         <= '0;
      latch_reg       <= '0;
      underrun_reg    <= 1'b0;
      done_reg        <= 1'b0;
      neo_reg         <= 1'b0;
    end else begin
      state_reg       <= state_next;
      index_reg       <= index_next;
      last_reg        <= last_next;
      shift_reg       <= shift_next;
      shadow_reg      <= shadow_next;
      shadow_full_reg <= shadow_full_next;
      slot_reg        <= slot_next;
      bit_reg         <= bit_next;
      latch_reg       <= latch_next;
      underrun_reg    <= underrun_next;
      done_reg        <= done_next;
      neo_reg         <= neo_next;
    end
  end

  assign bus.pixel_req   = req;
  assign bus.pixel_index = req_index;
  assign bus.busy        = (state_reg != IDLE);
  assign bus.done        = done_reg;
  assign bus.underrun    = underrun_reg;
  assign bus.neo_data    = neo_reg;

endmodule

// File: tb/tb_anton_neopixel_serializer.sv
// Bench for the NeoPixel serializer: a delay-programmable pixel buffer answers requests and
// the decoded line is checked slot by slot against a bit-level model of the frame.
module tb_anton_neopixel_serializer;
  localparam int CPB = 8;
  localparam int T0H = 2;
  localparam int T1H = 5;
  localparam int RC  = 350;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  anton_neopixel_serializer_if #(.BUFFER_BITS(3)) bus24 ();
  anton_neopixel_serializer_if #(.BUFFER_BITS(3)) bus32 ();

  anton_neopixel_serializer #(
    .CLK_PER_BIT(CPB), .T0H(T0H), .T1H(T1H), .RESET_CYCLES(RC),
    .BITS_PER_PIXEL(24), .BUFFER_END(7)
  ) u_dut24 (.clk(clk), .rst(rst), .bus(bus24.slave));

  anton_neopixel_serializer #(
    .CLK_PER_BIT(CPB), .T0H(T0H), .T1H(T1H), .RESET_CYCLES(RC),
    .BITS_PER_PIXEL(32), .BUFFER_END(7)
  ) u_dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

  logic        start = 1'b0;
  logic        loop_en = 1'b0;
  logic        valid;
  logic        sel = 1'b0;
  logic [2:0]  last_pixel = 3'd0;
  logic [31:0] data;

  assign bus24.start       = start & ~sel;
  assign bus32.start       = start & sel;
  assign bus24.loop_en     = loop_en;
  assign bus32.loop_en     = loop_en;
  assign bus24.last_pixel  = last_pixel;
  assign bus32.last_pixel  = last_pixel;
  assign bus24.pixel_valid = valid;
  assign bus32.pixel_valid = valid;
  assign bus24.pixel_data  = data;
  assign bus32.pixel_data  = data;

  logic       neo_w, req_w, busy_w, done_w, underrun_w;
  logic [2:0] idx_w;
  assign neo_w      = sel ? bus32.neo_data    : bus24.neo_data;
  assign req_w      = sel ? bus32.pixel_req   : bus24.pixel_req;
  assign idx_w      = sel ? bus32.pixel_index : bus24.pixel_index;
  assign busy_w     = sel ? bus32.busy        : bus24.busy;
  assign done_w     = sel ? bus32.done        : bus24.done;
  assign underrun_w = sel ? bus32.underrun    : bus24.underrun;

  int          checks = 0;
  int          failures = 0;
  int          delay_tab [8];
  logic [31:0] pix_mem [8];
  int          obs_q [$];
  int          exp_q [$];
  int          idx_log [$];
  int          done_cnt = 0;
  int          wcnt;

  // Pixel buffer: answers a request after delay_tab[index] cycles with a one-cycle valid.
  initial begin
    valid = 1'b0;
    data  = 32'd0;
    wcnt  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        valid = 1'b0;
        wcnt  = 0;
      end else begin
        if (valid) begin
          valid = 1'b0;
          wcnt  = 0;
        end
        if (req_w) begin
          if (wcnt >= delay_tab[idx_w]) begin
            valid = 1'b1;
            data  = pix_mem[idx_w];
          end else begin
            wcnt++;
          end
        end
      end
    end
  end

  always @(posedge clk) if (req_w && valid) idx_log.push_back(int'(idx_w));
  always @(negedge clk) if (done_w) done_cnt <= done_cnt + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: each bit becomes one slot whose high time depends only on the bit value.
  task automatic model_frame(input int first, input int last, input int bpp);
    for (int p = first; p <= last; p++) begin
      for (int b = 0; b < bpp; b++) begin
        exp_q.push_back((((pix_mem[p] >> (bpp - 1 - b)) & 32'd1) != 0) ? T1H : T0H);
      end
    end
  endtask

  task automatic set_delays(input int d);
    for (int i = 0; i < 8; i++) delay_tab[i] = d;
  endtask

  task automatic pulse_start(input logic [2:0] lp);
    last_pixel = lp;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_rise(input int maxc, output int waited);
    waited = -1;
    for (int i = 0; i < maxc; i++) begin
      if (neo_w) begin
        waited = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Records the high length of each slot; -1 marks a slot whose high part is not one leading run.
  task automatic capture_slots(input int n);
    for (int s = 0; s < n; s++) begin
      int  h;
      bit  shape_ok;
      h = 0;
      shape_ok = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        if (neo_w) begin
          if (c != h) shape_ok = 1'b0;
          h++;
        end
        @(negedge clk);
      end
      obs_q.push_back(shape_ok ? h : -1);
    end
  endtask

  task automatic capture_latch(output int lows);
    lows = 0;
    for (int i = 0; i < RC; i++) begin
      if (!neo_w && !done_w && busy_w) lows++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++; if (busy_w !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy_w); end
    checks++; if (done_w !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", done_w); end
    checks++; if (underrun_w !== 1'b0) begin failures++; $display("FAIL reset_underrun: got %b want 0", underrun_w); end
    checks++; if (neo_w !== 1'b0) begin failures++; $display("FAIL reset_neo: got %b want 0", neo_w); end
    checks++; if (req_w !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", req_w); end
    checks++; if (bus32.neo_data !== 1'b0) begin failures++; $display("FAIL reset_neo32: got %b want 0", bus32.neo_data); end
    $display("reset: outputs idle");
  endtask

  task automatic test_single_pixel();
    int waited, lows, base;
    sel = 1'b0; loop_en = 1'b0; set_delays(1);
    pix_mem[0] = 32'h00FF00D5;
    obs_q.delete(); exp_q.delete();
    model_frame(0, 0, 24);
    base = idx_log.size();
    pulse_start(3'd0);
    wait_rise(50, waited);
    checks++; if (waited < 0) begin failures++; $display("FAIL single_rise: got timeout want rise"); end
    capture_slots(24);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL single_slot%0d: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    capture_latch(lows);
    checks++; if (lows !== RC) begin failures++; $display("FAIL single_gap: got %0d want %0d", lows, RC); end
    checks++; if (done_w !== 1'b1) begin failures++; $display("FAIL single_done: got %b want 1", done_w); end
    checks++; if (busy_w !== 1'b0) begin failures++; $display("FAIL single_busy_fall: got %b want 0", busy_w); end
    @(negedge clk);
    checks++; if (done_w !== 1'b0) begin failures++; $display("FAIL single_done_pulse: got %b want 0", done_w); end
    checks++; if (underrun_w !== 1'b0) begin failures++; $display("FAIL single_underrun: got %b want 0", underrun_w); end
    checks++; if (idx_log.size() !== base + 1 || idx_log[base] !== 0) begin failures++; $display("FAIL single_index: got %0d fetches want 1 of index 0", idx_log.size() - base); end
    $display("single pixel frame: %0d slots captured", obs_q.size());
  endtask

  task automatic test_back_to_back();
    int waited, lows, base;
    sel = 1'b0; loop_en = 1'b0; set_delays(1);
    for (int i = 0; i < 8; i++) pix_mem[i] = $urandom;
    obs_q.delete(); exp_q.delete();
    model_frame(0, 2, 24);
    base = idx_log.size();
    pulse_start(3'd2);
    pulse_start(3'd0);
    wait_rise(50, waited);
    checks++; if (waited < 0) begin failures++; $display("FAIL b2b_rise: got timeout want rise"); end
    capture_slots(72);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL b2b_slot%0d: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    capture_latch(lows);
    checks++; if (lows !== RC) begin failures++; $display("FAIL b2b_gap: got %0d want %0d", lows, RC); end
    checks++; if (done_w !== 1'b1) begin failures++; $display("FAIL b2b_done: got %b want 1", done_w); end
    checks++; if (underrun_w !== 1'b0) begin failures++; $display("FAIL b2b_underrun: got %b want 0", underrun_w); end
    checks++; if (idx_log.size() !== base + 3) begin failures++; $display("FAIL b2b_fetches: got %0d want 3", idx_log.size() - base); end
    for (int k = 0; k < 3 && base + k < idx_log.size(); k++) begin
      checks++;
      if (idx_log[base + k] !== k) begin failures++; $display("FAIL b2b_index%0d: got %0d want %0d", k, idx_log[base + k], k); end
    end
    @(negedge clk);
    $display("back-to-back frame: 3 pixels, %0d slots captured", obs_q.size());
  endtask

  task automatic test_underrun();
    int waited, lows;
    sel = 1'b0; loop_en = 1'b0; set_delays(1);
    delay_tab[1] = 200;
    pix_mem[0] = $urandom; pix_mem[1] = $urandom;
    obs_q.delete(); exp_q.delete();
    model_frame(0, 1, 24);
    pulse_start(3'd1);
    wait_rise(50, waited);
    checks++; if (waited < 0) begin failures++; $display("FAIL ur_rise0: got timeout want rise"); end
    capture_slots(24);
    checks++; if (underrun_w !== 1'b1) begin failures++; $display("FAIL ur_flag: got %b want 1", underrun_w); end
    // The late pixel arrives 200 cycles after its request began, 192 of which were pixel 0.
    wait_rise(300, waited);
    checks++; if (waited !== 9) begin failures++; $display("FAIL ur_gap: got %0d low cycles want 9", waited); end
    capture_slots(24);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL ur_slot%0d: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    capture_latch(lows);
    checks++; if (lows !== RC) begin failures++; $display("FAIL ur_latch: got %0d want %0d", lows, RC); end
    checks++; if (done_w !== 1'b1) begin failures++; $display("FAIL ur_done: got %b want 1", done_w); end
    checks++; if (underrun_w !== 1'b1) begin failures++; $display("FAIL ur_sticky: got %b want 1", underrun_w); end
    @(negedge clk);
    set_delays(1);
    $display("underrun frame: gap of %0d cycles before pixel 1", waited);
  endtask

  task automatic test_loop();
    int waited, lows, base, dc0;
    sel = 1'b0; loop_en = 1'b1; set_delays(1);
    pix_mem[0] = $urandom; pix_mem[1] = $urandom;
    obs_q.delete(); exp_q.delete();
    model_frame(0, 1, 24);
    model_frame(0, 1, 24);
    base = idx_log.size();
    dc0 = done_cnt;
    pulse_start(3'd1);
    checks++; if (underrun_w !== 1'b0) begin failures++; $display("FAIL loop_underrun_clear: got %b want 0", underrun_w); end
    wait_rise(50, waited);
    checks++; if (waited < 0) begin failures++; $display("FAIL loop_rise0: got timeout want rise"); end
    capture_slots(48);
    capture_latch(lows);
    checks++; if (lows !== RC) begin failures++; $display("FAIL loop_gap0: got %0d want %0d", lows, RC); end
    checks++; if (done_w !== 1'b0) begin failures++; $display("FAIL loop_no_done: got %b want 0", done_w); end
    checks++; if (req_w !== 1'b1 || idx_w !== 3'd0) begin failures++; $display("FAIL loop_refetch: got req %b index %0d want req 1 index 0", req_w, idx_w); end
    wait_rise(50, waited);
    checks++; if (waited < 0) begin failures++; $display("FAIL loop_rise1: got timeout want rise"); end
    capture_slots(16);
    loop_en = 1'b0;
    capture_slots(32);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL loop_slot%0d: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    capture_latch(lows);
    checks++; if (lows !== RC) begin failures++; $display("FAIL loop_gap1: got %0d want %0d", lows, RC); end
    checks++; if (done_w !== 1'b1 || busy_w !== 1'b0) begin failures++; $display("FAIL loop_finish: got done %b busy %b want done 1 busy 0", done_w, busy_w); end
    @(negedge clk);
    @(negedge clk);
    checks++; if (done_cnt - dc0 !== 1) begin failures++; $display("FAIL loop_done_count: got %0d want 1", done_cnt - dc0); end
    checks++; if (idx_log.size() !== base + 4) begin failures++; $display("FAIL loop_fetches: got %0d want 4", idx_log.size() - base); end
    for (int k = 0; k < 4 && base + k < idx_log.size(); k++) begin
      checks++;
      if (idx_log[base + k] !== (k % 2)) begin failures++; $display("FAIL loop_index%0d: got %0d want %0d", k, idx_log[base + k], k % 2); end
    end
    $display("loop frame: two passes, %0d done pulses", done_cnt - dc0);
  endtask

  task automatic test_grbw();
    int waited, lows;
    sel = 1'b1; loop_en = 1'b0; set_delays(1);
    @(negedge clk);
    pix_mem[0] = 32'h80000001; pix_mem[1] = $urandom;
    obs_q.delete(); exp_q.delete();
    model_frame(0, 1, 32);
    pulse_start(3'd1);
    wait_rise(50, waited);
    checks++; if (waited < 0) begin failures++; $display("FAIL grbw_rise: got timeout want rise"); end
    capture_slots(64);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL grbw_slot%0d: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    capture_latch(lows);
    checks++; if (lows !== RC) begin failures++; $display("FAIL grbw_gap: got %0d want %0d", lows, RC); end
    checks++; if (done_w !== 1'b1 || busy_w !== 1'b0) begin failures++; $display("FAIL grbw_done: got done %b busy %b want done 1 busy 0", done_w, busy_w); end
    @(negedge clk);
    sel = 1'b0;
    @(negedge clk);
    $display("grbw frame: 2 pixels of 32 bits, %0d slots captured", obs_q.size());
  endtask

  task automatic test_reset_mid_frame();
    int waited, lows, base, dc0;
    sel = 1'b0; loop_en = 1'b0; set_delays(1);
    pix_mem[0] = $urandom; pix_mem[1] = $urandom;
    dc0 = done_cnt;
    pulse_start(3'd1);
    wait_rise(50, waited);
    checks++; if (waited < 0) begin failures++; $display("FAIL rmid_rise: got timeout want rise"); end
    repeat (10 * CPB) @(negedge clk);
    #1 rst = 1'b1;
    #1;
    checks++; if (neo_w !== 1'b0) begin failures++; $display("FAIL rmid_neo: got %b want 0", neo_w); end
    checks++; if (busy_w !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b want 0", busy_w); end
    checks++; if (req_w !== 1'b0) begin failures++; $display("FAIL rmid_req: got %b want 0", req_w); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (done_cnt !== dc0) begin failures++; $display("FAIL rmid_no_done: got %0d pulses want 0", done_cnt - dc0); end
    obs_q.delete(); exp_q.delete();
    model_frame(0, 1, 24);
    base = idx_log.size();
    pulse_start(3'd1);
    wait_rise(50, waited);
    checks++; if (waited < 0) begin failures++; $display("FAIL rmid_rise2: got timeout want rise"); end
    capture_slots(48);
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin failures++; $display("FAIL rmid_slot%0d: got %0d want %0d", i, obs_q[i], exp_q[i]); end
    end
    capture_latch(lows);
    checks++; if (done_w !== 1'b1) begin failures++; $display("FAIL rmid_done: got %b want 1", done_w); end
    checks++; if (idx_log.size() < base + 1 || idx_log[base] !== 0) begin failures++; $display("FAIL rmid_first_index: got %0d fetches want first index 0", idx_log.size() - base); end
    @(negedge clk);
    $display("reset mid-frame: restart frame of %0d slots captured", obs_q.size());
  endtask

  initial begin
    set_delays(1);
    for (int i = 0; i < 8; i++) pix_mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_pixel();
    test_back_to_back();
    test_underrun();
    test_loop();
    test_grbw();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
